// File: rtl/axis_burst_reader_if.sv
// Stream bundle for axis_burst_reader: upstream fifo side (level/idata/ivalid/iready)
// and downstream burst side (odata/ovalid/olast/oready).
interface axis_burst_reader_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] level;
    logic [DATA_WIDTH-1:0] idata;
    logic                  ivalid;
    logic                  iready;
    logic [DATA_WIDTH-1:0] odata;
    logic                  ovalid;
    logic                  olast;
    logic                  oready;

    // master: the burst reader itself
    modport master (
        input  level, idata, ivalid, oready,
        output iready, odata, ovalid, olast
    );

    // slave: the fifo + consumer environment around the reader
    modport slave (
        output level, idata, ivalid, oready,
        input  iready, odata, ovalid, olast
    );
endinterface

// File: rtl/axis_burst_reader.sv
// Drains a fifo stream and re-emits it as fixed-length bursts with olast on the final beat.
// Optional idle timeout that forces a partial burst: define AXIS_BURST_READER_TIMEOUT_EN.
module axis_burst_reader #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned BURST_LEN      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                resetn,
    axis_burst_reader_if.master bus,
    input  logic                flush,
    output logic                busy
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      remaining;
    logic [CNT_W-1:0]      level_ext;
    logic [DATA_WIDTH-1:0] odata_q;
    logic                  ovalid_q;
    logic                  olast_q;
    logic                  iready_c;
    logic                  in_fire;
    logic                  out_fire;
    logic                  start_full;
    logic                  start_partial;
    logic                  flush_eff;

    // Upstream is only accepted when the output register is free or emptying this cycle
    assign iready_c      = (state == BURST) && (remaining != '0) && (!ovalid_q || bus.oready);
    assign in_fire       = bus.ivalid && iready_c;
    assign out_fire      = ovalid_q && bus.oready;
    assign level_ext     = CNT_W'(bus.level);
    assign start_full    = level_ext >= CNT_W'(BURST_LEN);
    assign start_partial = flush_eff && (level_ext != '0);

    assign bus.iready = iready_c;
    assign bus.odata  = odata_q;
    assign bus.ovalid = ovalid_q;
    assign bus.olast  = olast_q;

`ifdef AXIS_BURST_READER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign flush_eff = flush || to_hit;

    // Idle timer: runs only while a partial burst is pending in IDLE
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            to_cnt <= '0;
        end else if ((state != IDLE) || (bus.level == '0) || to_hit || start_full || start_partial) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign flush_eff = flush;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            remaining <= '0;
            odata_q   <= '0;
            ovalid_q  <= 1'b0;
            olast_q   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Output register: load on input transfer, empty on accept, otherwise hold
            if (in_fire) begin
                odata_q  <= bus.idata;
                ovalid_q <= 1'b1;
                olast_q  <= (remaining == CNT_W'(1));
            end else if (bus.oready) begin
                ovalid_q <= 1'b0;
                olast_q  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_full) begin
                        remaining <= CNT_W'(BURST_LEN);
                        state     <= BURST;
                        busy      <= 1'b1;
                    end else if (start_partial) begin
                        remaining <= level_ext;
                        state     <= BURST;
                        busy      <= 1'b1;
                    end
                end
                BURST: begin
                    // Enter DRAIN together with the final load so the last beat is never missed
                    if (in_fire) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end else if (remaining == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire && olast_q) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_burst_reader.sv
// Self-checking bench for axis_burst_reader: fifo-like source queue, expected-beat scoreboard,
// per-cycle protocol monitor, directed scenarios. Timeout scenario built with AXIS_BURST_READER_TIMEOUT_EN.
module tb_axis_burst_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned BL = 8;
    localparam int unsigned TO = 10;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;
    logic busy;

    axis_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axis_burst_reader #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .BURST_LEN     (BL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.master),
        .flush (flush),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    beat_t         exp_q[$];
    logic [DW-1:0] src_q[$];
    int            beat_cyc_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            in_fires = 0;
    int            valid_seen = 0;
    logic [DW-1:0] last_data = '0;
    logic          fire_n = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_last_acc = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_olast = 1'b0;
    logic          oready_drv = 1'b1;
    logic          flush_drv = 1'b0;
    logic          bp_mode = 1'b0;

    function automatic void chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    // Source behaves as a fifo head: level counts every queued word including the presented one
    task automatic drive_inputs();
        bus.level  = (src_q.size() > 15) ? AW'(15) : AW'(src_q.size());
        bus.idata  = (src_q.size() != 0) ? src_q[0] : '0;
        bus.ivalid = (src_q.size() != 0);
        bus.oready = oready_drv;
        flush      = flush_drv;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (fire_n) begin
            void'(src_q.pop_front());
            fire_n = 1'b0;
        end
        if (bp_mode) oready_drv = ~oready_drv;
        drive_inputs();
    endtask

    task automatic push_burst(input int base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            src_q.push_back(DW'(base + i));
            b.data = DW'(base + i);
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_done"}, (exp_q.size() == 0 && !busy) ? 1 : 0, 1);
    endtask

    // Per-cycle protocol and scoreboard checks, sampled mid-cycle
    task automatic mon();
        beat_t e;
        cyc++;
        if (!resetn) begin
            fire_n        = 1'b0;
            prev_stall    = 1'b0;
            prev_last_acc = 1'b0;
            return;
        end
        if (prev_last_acc) chk("busy_fall", busy, 0);
        if (bus.ovalid) chk("busy_while_valid", busy, 1);
        if (!busy) chk("iready_idle", bus.iready, 0);
        if (prev_stall) begin
            chk("hold_valid", bus.ovalid, 1);
            chk("hold_data", bus.odata, prev_data);
            chk("hold_last", bus.olast, prev_olast);
        end
        if (bus.ovalid) valid_seen++;
        if (bus.ovalid && bus.oready) begin
            chk("beat_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", bus.odata, e.data);
                chk("beat_last", bus.olast, e.last);
            end
            beat_cyc_q.push_back(cyc);
            last_data = bus.odata;
        end
        fire_n = bus.ivalid && bus.iready;
        if (fire_n) in_fires++;
        prev_stall    = bus.ovalid && !bus.oready;
        prev_data     = bus.odata;
        prev_olast    = bus.olast;
        prev_last_acc = bus.ovalid && bus.oready && bus.olast;
    endtask

    initial begin
        int n;
        int v0;
        int i0;
        logic busy_any;

        drive_inputs();
        fork
            forever begin
                @(negedge clock);
                mon();
            end
        join_none

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ovalid", bus.ovalid, 0);
        chk("rst_olast", bus.olast, 0);
        chk("rst_odata", bus.odata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_iready", bus.iready, 0);
        resetn = 1'b1;
        step();

        // Full burst, no backpressure
        beat_cyc_q.delete();
        push_burst(0, 8);
        step();
        wait_done("full", 60);
        chk("full_beats", beat_cyc_q.size(), 8);
        chk("full_consecutive", (beat_cyc_q.size() == 8) ? beat_cyc_q[7] - beat_cyc_q[0] : -1, 7);
        chk("full_last_data", last_data, 7);

        // Backpressure with oready toggling
        beat_cyc_q.delete();
        bp_mode = 1'b1;
        push_burst(8, 8);
        step();
        wait_done("bp", 80);
        bp_mode    = 1'b0;
        oready_drv = 1'b1;
        step();
        chk("bp_beats", beat_cyc_q.size(), 8);
        chk("bp_last_data", last_data, 15);

        // Flush of a partial burst
        beat_cyc_q.delete();
        push_burst(8'hA0, 3);
        flush_drv = 1'b1;
        step();
        flush_drv = 1'b0;
        wait_done("flush", 40);
        chk("flush_beats", beat_cyc_q.size(), 3);
        chk("flush_last_data", last_data, 8'hA2);

        // Flush with nothing pending is ignored
        busy_any  = 1'b0;
        flush_drv = 1'b1;
        step();
        flush_drv = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            busy_any = busy_any | busy;
        end
        chk("flush_empty_busy", busy_any, 0);

`ifdef AXIS_BURST_READER_TIMEOUT_EN
        // Timeout: level=2 held starts a burst 11 cycles later
        beat_cyc_q.delete();
        push_burst(8'h60, 2);
        step();
        n = 0;
        while (!busy && n < 50) begin
            step();
            n++;
        end
        chk("timeout_start", n, 11);
        wait_done("timeout", 40);
        chk("timeout_beats", beat_cyc_q.size(), 2);
        chk("timeout_last_data", last_data, 8'h61);
`else
        // Below threshold without flush: nothing moves
        beat_cyc_q.delete();
        push_burst(8'h50, 5);
        step();
        v0 = valid_seen;
        i0 = in_fires;
        repeat (1000) step();
        chk("below_no_valid", valid_seen - v0, 0);
        chk("below_no_iready", in_fires - i0, 0);
        chk("below_busy", busy, 0);
        flush_drv = 1'b1;
        step();
        flush_drv = 1'b0;
        wait_done("below_flush", 40);
        chk("below_flush_beats", beat_cyc_q.size(), 5);
        chk("below_flush_last_data", last_data, 8'h54);
`endif

        // Reset mid-burst, then a fresh burst
        beat_cyc_q.delete();
        push_burst(8'h30, 8);
        step();
        n = 0;
        while (beat_cyc_q.size() < 3 && n < 50) begin
            step();
            n++;
        end
        chk("rst_mid_reached", (beat_cyc_q.size() >= 3) ? 1 : 0, 1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_ovalid", bus.ovalid, 0);
        chk("rst_mid_olast", bus.olast, 0);
        chk("rst_mid_busy", busy, 0);
        exp_q.delete();
        src_q.delete();
        fire_n = 1'b0;
        step();
        step();
        resetn = 1'b1;
        beat_cyc_q.delete();
        push_burst(8'h40, 8);
        step();
        wait_done("post_rst", 60);
        chk("post_rst_beats", beat_cyc_q.size(), 8);
        chk("post_rst_consecutive", (beat_cyc_q.size() == 8) ? beat_cyc_q[7] - beat_cyc_q[0] : -1, 7);
        chk("post_rst_last_data", last_data, 8'h47);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule

// File: doc/axis_burst_reader.md
Name: axis_burst_reader

Overview:
- Read-side companion of the team's axis fifos. It drains a fifo's output stream and uses the fifo's fill level to re-emit the data as fixed-length bursts, with olast marking each burst end.
- Sits between a fifo and a burst-oriented consumer, such as a USB/packet transmitter, that wants contiguous beats without bubbles.
- Partial bursts go out only on flush or, optionally, on timeout.

Parameters:
- DATA_WIDTH, 8, data bus width.
- ADDR_WIDTH, 4, width of the level input; must match the fifo.
- BURST_LEN, 8, beats per full burst; 1 <= BURST_LEN <= 2**ADDR_WIDTH-1.
- TIMEOUT_CYCLES, 255, idle cycles before an automatic partial burst; used only with the optional feature.

Ports:
- clock  input  1  single system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- level  input  ADDR_WIDTH  words available upstream, including the word currently presented on idata.
- idata  input  DATA_WIDTH  upstream data.
- ivalid  input  1  upstream valid.
- iready  output  1  upstream ready.
- flush  input  1  request to emit pending words as a partial burst; sampled in IDLE.
- odata  output  DATA_WIDTH  registered output data.
- ovalid  output  1  registered output valid.
- olast  output  1  registered; high on the final beat of each burst.
- oready  input  1  downstream ready.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset: all outputs and state are cleared on resetn low, immediately (asynchronous).
  - ovalid=0, olast=0, odata=0, busy=0, state=IDLE, beat counter=0.
  - A reset mid-burst abandons the burst. No olast is emitted for it.
- Handshakes: transfer in when ivalid&&iready; transfer out when ovalid&&oready.
  - Output register rule: iready = (state==BURST) && (remaining!=0) && (!ovalid || oready).
  - An input transfer loads odata/ovalid/olast on the next edge.
  - If oready is high and no new word loads, ovalid drops to 0 on the next edge.
  - While ovalid && !oready, odata/ovalid/olast hold stable.
- States:
  - IDLE: burst length len is decided and latched into remaining (ADDR_WIDTH+1 bits wide) as follows:
    - if level >= BURST_LEN, len=BURST_LEN and go to BURST next cycle;
    - else if flush && level!=0, len=level and go to BURST;
    - else stay in IDLE.
  - IDLE with level==0: flush is ignored.
  - BURST: each input transfer decrements remaining. The transfer taking remaining from 1 to 0 loads olast=1 with its word.
  - BURST exit: go to DRAIN when remaining==0.
  - Upstream stall (ivalid low) inside BURST: wait, no timeout, no olast. Upstream is required to honour level.
  - DRAIN: wait until the last beat (olast=1) is accepted (ovalid&&oready&&olast), then go to IDLE. No new burst starts in DRAIN, so at least one IDLE cycle separates bursts.
- Every burst has exactly len beats. olast appears on beat len and only there. Beat count never wraps.
- level is compared as unsigned. level==2**ADDR_WIDTH-1 (fifo full) is legal.
- level and flush are ignored outside IDLE.

Optional Feature:
- Macro: AXIS_BURST_READER_TIMEOUT_EN.
- Defined:
  - A counter of ceil(log2(TIMEOUT_CYCLES+1)) bits increments each cycle in IDLE while 0<level<BURST_LEN.
  - It clears on leaving IDLE or when level==0.
  - On reaching TIMEOUT_CYCLES it acts exactly as flush for that cycle, and the counter clears.
  - The counter resets to 0 on resetn.
- Undefined: no counter; partial bursts occur only via flush.

Test Plan:
- Full burst: BURST_LEN=8, level=8, ivalid=1, oready=1, data 0..7 -> odata 0..7 on 8 consecutive cycles; olast only with 7; busy falls one cycle after olast accepted.
- Backpressure: as above with oready toggling 1,0,1,0 -> no beat lost or duplicated; odata stable while oready=0; exactly 8 beats, olast on the 8th.
- Flush: level=3, flush pulse, data A,B,C -> 3 beats, olast on C. Separately, flush with level=0 -> busy stays 0.
- Below threshold: level=5, no flush, 1000 cycles (feature off) -> ovalid never asserts, iready stays 0.
- Timeout (feature on, TIMEOUT_CYCLES=10): level=2 held -> burst starts 11 cycles after level became 2; 2 beats, olast on the 2nd.
- Reset mid-burst: assert resetn=0 after beat 3 of 8 -> ovalid, olast and busy go 0 immediately. After release with level=8, a fresh 8-beat burst is emitted.
